sprite_calc_engine: RTL and testbench
=====================================

SPRITE_CALC_ENGINE -- requirements
Module: sprite_calc_engine

Interface
REQ-001 Parameters: NUM_SRC, default 4, number of selectable sprite-word sources; X_W, default 8, x field width; Y_W, default 7, y field width; C_W, default 3, color field width; X_MAX, default 159, largest legal x; Y_MAX, default 119, largest legal y.
REQ-002 Word layout SHALL be {x[X_W], y[Y_W], color[C_W]}, MSB first; W = X_W+Y_W+C_W (18 at defaults).
REQ-003 Ports: clock  in  1  rising-edge clock; reset  in  1  synchronous, active-high; src_in  in  NUM_SRC*W  packed source words, source k at bits [k*W +: W]; src_sel  in  clog2(NUM_SRC)  source select; op  in  3  operation code; delta  in  4  signed step per iteration; count  in  3  iteration count minus one; color_in  in  C_W  color for SET_COLOR; in_valid  in  1  request; in_ready  out  1  request accepted when high with in_valid; out_data  out  W  result word; out_clip  out  1  a bound was hit during the request; out_valid  out  1  result present; out_ready  in  1  consumer accepts result.

Function
REQ-004 Ops SHALL be PASS=0, MOVE_X=1, MOVE_Y=2, MOVE_XY=3 (delta on both axes), SET_COLOR=4, ERASE=5 (color 0); codes 6-7 SHALL behave as PASS.
REQ-005 FSM states SHALL be IDLE, STEP, DONE; reset enters IDLE.
REQ-006 IDLE: in_ready=1; on in_valid, latch src word, op, delta, count, color_in; go to STEP if op is MOVE_*, else DONE.
REQ-007 STEP: apply delta once per cycle to the selected axes, count+1 iterations total, then DONE.
REQ-008 Non-move ops SHALL modify only the color field; move ops SHALL preserve the color field; unselected axes SHALL be unchanged.
REQ-009 DONE: out_valid=1, out_data and out_clip stable; on out_ready go to IDLE.
REQ-010 in_ready SHALL be 0 in STEP and DONE; no request is accepted while busy.
REQ-011 Latency, accept to out_valid: 1 cycle for non-move ops, count+2 cycles for move ops.
REQ-012 Axis arithmetic SHALL be performed one bit wider than the field, signed.
REQ-013 Saturating mode: result <0 SHALL clamp to 0, result >MAX SHALL clamp to MAX, and set out_clip.
REQ-014 out_clip SHALL clear on each new accept and be sticky across iterations of one request.
REQ-015 A source word whose x>X_MAX or y>Y_MAX SHALL be clamped to MAX before the first step, setting out_clip.

Reset
REQ-016 While reset is high at a clock edge, state=IDLE, out_valid=0, out_clip=0, out_data=0, internal counters=0; in_ready is 1 the first cycle after reset deasserts.
REQ-017 Reset mid-STEP or mid-DONE SHALL abandon the request with no output produced.

Configuration
REQ-018 Macro SPRITE_CALC_WRAP_EN defined: axis results SHALL wrap modulo MAX+1 (underflow from 0 by -1 gives MAX) and out_clip SHALL assert on each wrap; undefined: saturate per REQ-013.

Structure
REQ-019 Package sprite_calc_pkg SHALL hold the op-code enum, FSM state enum and default field-width constants.
REQ-020 One sub-module, sprite_axis_step, SHALL implement a single-axis add with saturate/wrap and clip flag, instantiated once per axis.

Verification
REQ-021 MOVE_X, src x=10, delta=+3, count=2 -> out_valid 4 cycles after accept, x=19, y and color unchanged, out_clip=0.
REQ-022 MOVE_Y, y=118, delta=+2, count=0 -> saturating: y=119, out_clip=1; WRAP_EN: y=0, out_clip=1.
REQ-023 MOVE_XY, x=0, y=5, delta=-1, count=0 -> saturating: x=0, y=4, out_clip=1.
REQ-024 SET_COLOR color_in=4 on src_sel=2 -> out_valid next cycle, color=4, x/y equal source 2.
REQ-025 out_ready held low 5 cycles in DONE -> out_data stable, in_ready=0, new in_valid ignored; then accepted after out_ready.
REQ-026 reset asserted during STEP with count=7 -> next cycle IDLE, out_valid=0, no result emitted.

Source files
------------

// File: rtl/sprite_calc_pkg.sv
// Shared op codes, FSM states and default field geometry for the sprite calculation engine.
package sprite_calc_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_C_W     = 3;
    localparam int DEF_X_MAX   = 159;
    localparam int DEF_Y_MAX   = 119;
    localparam int OP_W        = 3;
    localparam int DELTA_W     = 4;
    localparam int COUNT_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_PASS      = 3'd0,
        OP_MOVE_X    = 3'd1,
        OP_MOVE_Y    = 3'd2,
        OP_MOVE_XY   = 3'd3,
        OP_SET_COLOR = 3'd4,
        OP_ERASE     = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_DONE
    } state_e;

    function automatic logic moves_x(input logic [OP_W-1:0] op);
        return (op == OP_MOVE_X) || (op == OP_MOVE_XY);
    endfunction

    function automatic logic moves_y(input logic [OP_W-1:0] op);
        return (op == OP_MOVE_Y) || (op == OP_MOVE_XY);
    endfunction

endpackage

// File: rtl/sprite_calc_engine_if.sv
// Request/response bundle of the sprite calculation engine; master drives requests, slave answers.
interface sprite_calc_engine_if
    import sprite_calc_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W
);
    localparam int W     = X_W + Y_W + C_W;
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*W-1:0] src_in;
    logic [SEL_W-1:0]     src_sel;
    logic [OP_W-1:0]      op;
    logic [DELTA_W-1:0]   delta;
    logic [COUNT_W-1:0]   count;
    logic [C_W-1:0]       color_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         out_data;
    logic                 out_clip;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output src_in, src_sel, op, delta, count, color_in, in_valid, out_ready,
        input  in_ready, out_data, out_clip, out_valid
    );

    modport slave (
        input  src_in, src_sel, op, delta, count, color_in, in_valid, out_ready,
        output in_ready, out_data, out_clip, out_valid
    );

endinterface

// File: rtl/sprite_axis_step.sv
// One signed step on a single axis; saturates by default, wraps modulo MAX+1 under SPRITE_CALC_WRAP_EN.
module sprite_axis_step
    import sprite_calc_pkg::*;
#(
    parameter int F_W = DEF_X_W,
    parameter int MAX = DEF_X_MAX
) (
    input  logic [F_W-1:0]            value,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      en,
    output logic [F_W-1:0]            result,
    output logic                      clip
);
    localparam logic signed [F_W:0] MAX_S  = (F_W+1)'(MAX);
    localparam logic signed [F_W:0] SPAN_S = (F_W+1)'(MAX + 1);

    logic signed [F_W:0] sum;
    logic signed [F_W:0] fixed;
    logic                hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum   = $signed({1'b0, value}) + $signed({{(F_W+1-DELTA_W){delta[DELTA_W-1]}}, delta});
        fixed = sum;
        hit   = 1'b0;
        if (sum[F_W]) begin
            hit = 1'b1;
`ifdef SPRITE_CALC_WRAP_EN
            fixed = sum + SPAN_S;
`else
            fixed = '0;
`endif
        end else if (sum > MAX_S) begin
            hit = 1'b1;
`ifdef SPRITE_CALC_WRAP_EN
            fixed = sum - SPAN_S;
`else
            fixed = MAX_S;
`endif
        end
        result = en ? fixed[F_W-1:0] : value;
        clip   = en & hit;
    end

endmodule

// File: rtl/sprite_calc_engine.sv
// Sprite word calculator: latches one request, steps x/y once per cycle, holds the result until taken.
// Define SPRITE_CALC_WRAP_EN to make the axes wrap instead of saturate.
module sprite_calc_engine
    import sprite_calc_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int Y_MAX   = DEF_Y_MAX
) (
    input logic                 clock,
    input logic                 reset,
    sprite_calc_engine_if.slave bus
);
    localparam int W = X_W + Y_W + C_W;
    localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MAX_V = Y_W'(Y_MAX);

    state_e                    state, state_next;
    logic [X_W-1:0]            x_q, x_step;
    logic [Y_W-1:0]            y_q, y_step;
    logic [C_W-1:0]            color_q;
    logic                      clip_q, x_clip, y_clip;
    logic                      move_x_q, move_y_q;
    logic signed [DELTA_W-1:0] delta_q;
    logic [COUNT_W-1:0]        count_q;
    logic [W-1:0]              src_word;
    logic [X_W-1:0]            src_x;
    logic [Y_W-1:0]            src_y;
    logic [C_W-1:0]            src_c;
    logic                      req_move;

    always_comb begin
        src_word = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(bus.src_sel) == k) src_word = bus.src_in[k*W +: W];
        end
    end

    assign src_x    = src_word[W-1 -: X_W];
    assign src_y    = src_word[C_W +: Y_W];
    assign src_c    = src_word[C_W-1:0];
    assign req_move = moves_x(bus.op) | moves_y(bus.op);

    sprite_axis_step #(.F_W(X_W), .MAX(X_MAX)) u_step_x (
        .value(x_q), .delta(delta_q), .en(move_x_q), .result(x_step), .clip(x_clip)
    );

    sprite_axis_step #(.F_W(Y_W), .MAX(Y_MAX)) u_step_y (
        .value(y_q), .delta(delta_q), .en(move_y_q), .result(y_step), .clip(y_clip)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = req_move ? ST_STEP : ST_DONE;
            end
            ST_STEP: if (count_q == '0) state_next = ST_DONE;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            clip_q   <= 1'b0;
            move_x_q <= 1'b0;
            move_y_q <= 1'b0;
            delta_q  <= '0;
            count_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    move_x_q <= moves_x(bus.op);
                    move_y_q <= moves_y(bus.op);
                    delta_q  <= bus.delta;
                    count_q  <= bus.count;
                    case (bus.op)
                        OP_SET_COLOR: color_q <= bus.color_in;
                        OP_ERASE:     color_q <= '0;
                        default:      color_q <= src_c;
                    endcase
                    // Out-of-range sources are pulled into the legal area before any step is taken.
                    if (req_move) begin
                        x_q    <= (src_x > X_MAX_V) ? X_MAX_V : src_x;
                        y_q    <= (src_y > Y_MAX_V) ? Y_MAX_V : src_y;
                        clip_q <= (src_x > X_MAX_V) | (src_y > Y_MAX_V);
                    end else begin
                        x_q    <= src_x;
                        y_q    <= src_y;
                        clip_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    x_q    <= x_step;
                    y_q    <= y_step;
                    clip_q <= clip_q | x_clip | y_clip;
                    if (count_q != '0) count_q <= count_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = {x_q, y_q, color_q};
    assign bus.out_clip = clip_q;

endmodule

// File: tb/tb_sprite_calc_engine.sv
// Scoreboard bench for sprite_calc_engine: directed corner requests plus random traffic against a plain-arithmetic model.
module tb_sprite_calc_engine;

    localparam int NUM_SRC = 4;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int X_MAX   = 159;
    localparam int Y_MAX   = 119;
    localparam int W       = X_W + Y_W + C_W;
`ifdef SPRITE_CALC_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         clip;
        int           lat;
        int           acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold_low = 1'b0;
    exp_t sb[$];

    sprite_calc_engine_if #(.NUM_SRC(NUM_SRC), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

    sprite_calc_engine #(
        .NUM_SRC(NUM_SRC), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input int x, input int y, input int c);
        logic [31:0] xv, yv, cv;
        xv = x;
        yv = y;
        cv = c;
        return {xv[X_W-1:0], yv[Y_W-1:0], cv[C_W-1:0]};
    endfunction

    function automatic int axis_move(input int v, input int d, input int mx, inout logic clip);
        int s;
        s = v + d;
        if (s < 0 || s > mx) begin
            clip = 1'b1;
            if (WRAP) s = ((s % (mx + 1)) + (mx + 1)) % (mx + 1);
            else      s = (s < 0) ? 0 : mx;
        end
        return s;
    endfunction

    // Reference: decode the word, clamp once for moves, then take count+1 steps on the chosen axes.
    function automatic void model(input logic [W-1:0] src, input int op, input int d, input int cnt,
                                  input int col, output logic [W-1:0] res, output logic clip);
        int x, y, c;
        bit mvx, mvy;
        x    = int'(src[W-1 -: X_W]);
        y    = int'(src[C_W +: Y_W]);
        c    = int'(src[C_W-1:0]);
        clip = 1'b0;
        mvx  = (op == 1) || (op == 3);
        mvy  = (op == 2) || (op == 3);
        if (op == 4)      c = col;
        else if (op == 5) c = 0;
        if (mvx || mvy) begin
            if (x > X_MAX) begin x = X_MAX; clip = 1'b1; end
            if (y > Y_MAX) begin y = Y_MAX; clip = 1'b1; end
            for (int i = 0; i <= cnt; i++) begin
                if (mvx) x = axis_move(x, d, X_MAX, clip);
                if (mvy) y = axis_move(y, d, Y_MAX, clip);
            end
        end
        res = pack(x, y, c);
    endfunction

    // Presents a request (held across any busy period) and queues its expectation once accepted.
    task automatic send(input logic [W-1:0] src_word, input int sel, input logic [2:0] op,
                        input logic [3:0] d4, input logic [2:0] cnt, input logic [2:0] col,
                        input logic [W-1:0] exp_data, input logic exp_clip, input bit expect_out);
        exp_t e;
        int   waited;
        for (int k = 0; k < NUM_SRC; k++) bus.src_in[k*W +: W] = W'($urandom);
        bus.src_in[sel*W +: W] = src_word;
        bus.src_sel  = 2'(sel);
        bus.op       = op;
        bus.delta    = d4;
        bus.count    = cnt;
        bus.color_in = col;
        bus.in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=no_in_ready required=in_ready op=%0d", op);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.data = exp_data;
        e.clip = exp_clip;
        e.lat  = (op == 3'd1 || op == 3'd2 || op == 3'd3) ? int'(cnt) + 2 : 1;
        e.acc  = cyc + 1;
        if (expect_out) sb.push_back(e);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] word, res;
        logic [3:0]   d4;
        logic [2:0]   op, cnt, col;
        logic         clip;
        int           sel;
        word = W'($urandom);
        sel  = $urandom_range(NUM_SRC - 1);
        op   = 3'($urandom);
        d4   = 4'($urandom);
        cnt  = 3'($urandom);
        col  = 3'($urandom);
        model(word, int'(op), int'($signed(d4)), int'(cnt), int'(col), res, clip);
        send(word, sel, op, d4, cnt, col, res, clip, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", sb.size());
        end
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        #1;
        bus.out_ready = hold_low ? 1'b0 : ($urandom_range(3) != 0);
    end

    // Monitor: compares each presented result with the queue head and watches it stay stable until taken.
    bit           seen = 1'b0;
    logic [W-1:0] held_data;
    logic         held_clip;
    always @(negedge clock) begin
        exp_t cur;
        if (reset) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            check("in_ready_while_done", 32'(bus.in_ready), 32'd0);
            if (!seen) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=no_output", bus.out_data);
                end else begin
                    cur = sb[0];
                    check("out_data", 32'(bus.out_data), 32'(cur.data));
                    check("out_clip", 32'(bus.out_clip), 32'(cur.clip));
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
                seen      = 1'b1;
                held_data = bus.out_data;
                held_clip = bus.out_clip;
            end else begin
                check("out_data_stable", 32'(bus.out_data), 32'(held_data));
                check("out_clip_stable", 32'(bus.out_clip), 32'(held_clip));
            end
            if (bus.out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    initial begin
        int n_out;
        bus.src_in    = '0;
        bus.src_sel   = '0;
        bus.op        = '0;
        bus.delta     = '0;
        bus.count     = '0;
        bus.color_in  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_out_clip", 32'(bus.out_clip), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #1;

        send(pack(10, 50, 5), 1, 3'd1, 4'd3, 3'd2, 3'd0, pack(19, 50, 5), 1'b0, 1'b1);
        send(pack(20, 118, 2), 0, 3'd2, 4'd2, 3'd0, 3'd0, pack(20, WRAP ? 0 : 119, 2), 1'b1, 1'b1);
        send(pack(0, 5, 7), 3, 3'd3, 4'hF, 3'd0, 3'd0, pack(WRAP ? 159 : 0, 4, 7), 1'b1, 1'b1);
        send(pack(33, 44, 1), 2, 3'd4, 4'd0, 3'd0, 3'd4, pack(33, 44, 4), 1'b0, 1'b1);
        send(pack(200, 125, 6), 1, 3'd1, 4'd1, 3'd0, 3'd0, pack(WRAP ? 0 : 159, 119, 6), 1'b1, 1'b1);
        send(pack(200, 125, 6), 0, 3'd5, 4'd3, 3'd1, 3'd2, pack(200, 125, 0), 1'b0, 1'b1);
        send(pack(77, 88, 3), 1, 3'd7, 4'd5, 3'd4, 3'd2, pack(77, 88, 3), 1'b0, 1'b1);
        send(pack(150, 110, 2), 3, 3'd3, 4'd7, 3'd3, 3'd0,
             WRAP ? pack(18, 18, 2) : pack(159, 119, 2), 1'b1, 1'b1);
        send(pack(20, 60, 1), 2, 3'd1, 4'h8, 3'd1, 3'd0, pack(4, 60, 1), 1'b0, 1'b1);
        send(pack(30, 3, 1), 0, 3'd2, 4'h8, 3'd0, 3'd0, pack(30, WRAP ? 115 : 0, 1), 1'b1, 1'b1);
        drain();

        // Consumer stalls five-plus cycles while a second request waits at the input.
        hold_low = 1'b1;
        send(pack(60, 70, 1), 0, 3'd4, 4'd0, 3'd0, 3'd6, pack(60, 70, 6), 1'b0, 1'b1);
        fork
            send(pack(90, 30, 5), 1, 3'd0, 4'd2, 3'd3, 3'd1, pack(90, 30, 5), 1'b0, 1'b1);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clock);
                    check("in_ready_stalled", 32'(bus.in_ready), 32'd0);
                end
                hold_low = 1'b0;
            end
        join
        drain();

        for (int i = 0; i < 60; i++) send_rand();
        drain();

        // Reset in the middle of a long move: nothing may come out.
        send(pack(40, 40, 3), 2, 3'd1, 4'd1, 3'd7, 3'd0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midstep_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midstep_reset_out_data", 32'(bus.out_data), 32'd0);
        check("midstep_reset_out_clip", 32'(bus.out_clip), 32'd0);
        check("midstep_reset_in_ready", 32'(bus.in_ready), 32'd1);
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.out_valid) n_out++;
        end
        check("no_output_after_reset", 32'(n_out), 32'd0);
        @(posedge clock);
        #1;

        send(pack(100, 100, 4), 1, 3'd3, 4'h1, 3'd1, 3'd0, pack(102, 102, 4), 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
